uart_tx_ctrl: RTL

//  Frame sequencer for the UART transmitter. Accepts a parallel byte and

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
// FSM state encoding and serial line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer, one bit per clk.
// Start, LSB-first data, optional parity, stop bit(s).
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  par_bit,
    output logic [DATA_WIDTH-1:0] par_data,
    output logic                  par_typ_q,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_ready
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST =
        CNT_W'(DATA_WIDTH - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  par_en_q;
    logic                  tx_nxt;
    logic                  stop_last;
    logic                  accept;
    logic                  bit_last;

    assign stop_last = (stop_cnt == STOP_LAST);
    assign bit_last  = (bit_cnt == BIT_LAST);
    assign tx_ready  = (state == IDLE) |
                       ((state == STOP) & stop_last);
    assign accept    = data_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rest) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tx_out is registered, so the level for the
    // upcoming cycle is chosen alongside the next state.
    always_comb begin
        state_nxt = state;
        tx_nxt    = IDLE_LVL;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    tx_nxt    = START_LVL;
                end
            end
            START: begin
                state_nxt = DATA;
                tx_nxt    = shift_reg[0];
            end
            DATA: begin
                if (!bit_last) begin
                    tx_nxt = shift_reg[0];
                end else if (par_en_q) begin
                    state_nxt = PARITY;
                    tx_nxt    = par_bit;
                end else begin
                    state_nxt = STOP;
                    tx_nxt    = STOP_LVL;
                end
            end
            PARITY: begin
                state_nxt = STOP;
                tx_nxt    = STOP_LVL;
            end
            STOP: begin
                if (!stop_last) begin
                    tx_nxt = STOP_LVL;
                end else if (accept) begin
                    state_nxt = START;
                    tx_nxt    = START_LVL;
                end else begin
                    state_nxt = IDLE;
                    tx_nxt    = IDLE_LVL;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            tx_out    <= IDLE_LVL;
            busy      <= 1'b0;
            shift_reg <= '0;
            par_data  <= '0;
            par_typ_q <= 1'b0;
            par_en_q  <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            tx_out <= tx_nxt;
            busy   <= (state_nxt != IDLE);

            if (accept) begin
                shift_reg <= p_data;
                par_data  <= p_data;
                par_typ_q <= par_typ;
                par_en_q  <= par_en;
            end else if (state == START ||
                         state == DATA) begin
                shift_reg <= shift_reg >> 1;
            end

            if (state == DATA && !bit_last) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end

            if (state == STOP && !stop_last) begin
                stop_cnt <= stop_cnt + 1'b1;
            end else begin
                stop_cnt <= 1'b0;
            end
        end
    end

endmodule
